regfile_mpmw_ctx: RTL and testbench
===================================

// Module: regfile_mpmw_ctx
// PURPOSE
//  Parametrised multi-read / multi-write register file for the M/A/S datapath, with DM lane write, DM lane read and a
//  context save/restore engine that streams the whole file to or from an external memory one word per cycle.
//  Sits between the issue stage (read ports), the writeback stage (write ports) and the data-memory/context controller.
// PARAMETERS
//  W      16  data width per register
//  DEPTH  16  number of registers (power of 2)
//  AW     4   address width, = clog2(DEPTH)
//  NR     5   number of datapath read ports
//  NW     3   number of datapath write ports
//  LANES  5   number of DM write lanes (dm_data_w is LANES*W wide, lane 0 in the MSBs)
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        reset, synchronous, active-low
//  rd_addr        in   NR*AW    read addresses, port i at [i*AW +: AW]
//  rd_data        out  NR*W     read data, port i at [i*W +: W]
//  wr_en          in   NW       per-port write enable
//  wr_addr        in   NW*AW    write addresses
//  wr_data        in   NW*W     write data
//  dm_wen         in   1        DM lane write strobe (all lanes)
//  dm_addr_w      in   LANES*AW DM lane destination addresses, lane 0 in the MSBs
//  dm_data_w      in   LANES*W  DM lane data, lane 0 in the MSBs
//  dm_addr_r      in   AW       DM read address
//  dm_data_r      out  W        DM read data
//  ctx_req        in   1        start context transfer (sampled in IDLE only)
//  ctx_dir        in   1        0 = save (file -> mem), 1 = restore (mem -> file); sampled with ctx_req
//  ctx_busy       out  1        engine active; external writes are dropped while high
//  ctx_done       out  1        one-cycle pulse at end of transfer
//  ctx_mem_addr   out  AW       memory word address
//  ctx_mem_we     out  1        memory write strobe (save)
//  ctx_mem_wdata  out  W        memory write data (save)
//  ctx_mem_rdata  in   W        memory read data, valid 1 cycle after ctx_mem_addr (restore)
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all registers = 0, FSM -> IDLE, ctx_busy=0, ctx_done=0, ctx_mem_we=0, ctx_mem_addr=0.
//  - Reads are combinational: rd_data and dm_data_r show the current register contents; 0 latency.
//  - Writes commit at the clk edge. Priority on the same address, lowest to highest: wr port 0..NW-1 < DM lane
//    0..LANES-1 < restore engine. The higher-priority source alone determines the final value; no merge.
//  - While ctx_busy=1, all wr_en and dm_wen writes are dropped (not queued).
//  - FSM IDLE -> SAVE | LOAD when ctx_req=1 (ctx_dir selects). ctx_busy=1 in every state except IDLE.
//    A ctx_req outside IDLE is ignored.
//  - SAVE: for k = 0..DEPTH-1 on successive cycles, ctx_mem_addr=k, ctx_mem_we=1, ctx_mem_wdata=reg[k].
//    After k=DEPTH-1 -> DONE. Takes DEPTH cycles.
//  - LOAD: ctx_mem_addr = k for k = 0..DEPTH-1; reg[k-1] <= ctx_mem_rdata in the cycle that presents addr k.
//    After addr DEPTH-1 -> LAST, which writes reg[DEPTH-1] -> DONE. Takes DEPTH+1 cycles. ctx_mem_we=0.
//  - DONE: ctx_done=1 for exactly one cycle, ctx_busy=1; -> IDLE. A ctx_req in the DONE cycle is ignored.
//  - The address counter is AW+1 bits wide, so the terminal test never aliases.
//  - Reset mid-transfer aborts at once: FSM -> IDLE, file cleared; no ctx_done pulse.
// CONFIGURATION
//  RF_BYPASS_EN defined: a read whose address matches a write committing this cycle returns the new data, using the
//    same priority as the write (applies to rd_data and dm_data_r; restore writes are bypassed as well).
//  RF_BYPASS_EN undefined: reads return the pre-edge contents (as described under BEHAVIOUR).
// STRUCTURE
//  Shared package rf_pkg: ctx_state_t enum {IDLE, SAVE, LOAD, LAST, DONE}; localparams CTX_DIR_SAVE=0, CTX_DIR_LOAD=1.
//  One sub-module, rf_ctx_seq: FSM plus address counter, driving ctx_* signals and a restore write-enable/addr/data
//  into the file. The storage array and the priority write mux stay in the top module.
// TESTING
//  1 Reset clears: write 0xBEEF to r3, rst_n=0 for 1 cycle -> rd_data port0 (addr 3) = 0x0000; ctx_busy=0.
//  2 Priority: same cycle wr port0 r5=0x1111, port2 r5=0x2222, dm lane4 r5=0x3333 -> r5=0x3333;
//    repeat without dm_wen -> r5=0x2222.
//  3 Save: preload reg[k]=0x100+k, pulse ctx_req, ctx_dir=0 -> 16 cycles of ctx_mem_we=1, addr k, wdata 0x100+k;
//    ctx_done one cycle later; busy for 17 cycles.
//  4 Restore: memory model returns 0xA000+addr after 1 cycle; ctx_dir=1 -> after ctx_done reg[k]=0xA000+k for all k;
//    wr_en to r2 mid-transfer is dropped.
//  5 Abort: rst_n=0 at LOAD k=7 -> IDLE next cycle, no ctx_done, all regs 0; new ctx_req then completes normally.
//  6 Bypass (RF_BYPASS_EN): wr port1 r9=0x5A5A with rd_addr0=9 -> same-cycle rd_data0=0x5A5A;
//    without the macro, old value.

Source files
------------

// File: rtl/regfile_mpmw_ctx_pkg.sv
// ============================================================================
// Package     : rf_pkg
// Description : Shared types and constants for the multi-port register file
//               and its context save/restore sequencer.
//               ctx_state_t  - context engine state encoding
//               CTX_DIR_*    - encoding of the ctx_dir request input
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SAVE = 3'd1,
      LOAD = 3'd2,
      LAST = 3'd3,
      DONE = 3'd4
   } ctx_state_t;

   localparam logic CTX_DIR_SAVE = 1'b0;
   localparam logic CTX_DIR_LOAD = 1'b1;

endpackage

`default_nettype wire

// File: rtl/regfile_mpmw_ctx_ctx_seq.sv
// ============================================================================
// Module      : rf_ctx_seq
// Description : Context save/restore sequencer. Streams the register file to
//               or from an external memory one word per cycle.
// Ports       : clk, rst_n          clock, synchronous active-low reset
//               ctx_req, ctx_dir    start request and direction (IDLE only)
//               save_data           file contents at ctx_mem_addr (save)
//               ctx_mem_rdata       memory data, one cycle after the address
//               ctx_busy, ctx_done  engine active / end-of-transfer pulse
//               ctx_mem_addr/we/wdata  memory side of the transfer
//               restore_we/addr/data   restore write into the file
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_ctx_seq
   import rf_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ctx_req,
   input  logic          ctx_dir,
   input  logic [W-1:0]  save_data,
   input  logic [W-1:0]  ctx_mem_rdata,
   output logic          ctx_busy,
   output logic          ctx_done,
   output logic [AW-1:0] ctx_mem_addr,
   output logic          ctx_mem_we,
   output logic [W-1:0]  ctx_mem_wdata,
   output logic          restore_we,
   output logic [AW-1:0] restore_addr,
   output logic [W-1:0]  restore_data
);

   localparam logic [AW:0]   c_cnt_last = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0]   c_cnt_one  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] c_addr_one = {{(AW-1){1'b0}}, 1'b1};

   ctx_state_t   r_state;
   logic [AW:0]  r_cnt;
   logic         r_busy;
   logic         r_done;
   logic         r_we;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_we    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (ctx_req) begin
                  r_cnt  <= '0;
                  r_busy <= 1'b1;
                  if (ctx_dir == CTX_DIR_LOAD) begin
                     r_state <= LOAD;
                     r_we    <= 1'b0;
                  end else begin
                     r_state <= SAVE;
                     r_we    <= 1'b1;
                  end
               end
            end
            SAVE: begin
               if (r_cnt == c_cnt_last) begin
                  r_state <= DONE;
                  r_we    <= 1'b0;
                  r_done  <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + c_cnt_one;
               end
            end
            LOAD: begin
               // Count past the last address so LAST sees cnt=DEPTH and the
               // shared restore address (cnt-1) lands on DEPTH-1.
               r_cnt <= r_cnt + c_cnt_one;
               if (r_cnt == c_cnt_last) begin
                  r_state <= LAST;
               end
            end
            LAST: begin
               r_state <= DONE;
               r_done  <= 1'b1;
               r_cnt   <= '0;
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_we    <= 1'b0;
            end
         endcase
      end
   end

   assign ctx_busy      = r_busy;
   assign ctx_done      = r_done;
   assign ctx_mem_addr  = r_cnt[AW-1:0];
   assign ctx_mem_we    = r_we;
   assign ctx_mem_wdata = r_we ? save_data : '0;

   // Memory data trails the address by one cycle, so the word arriving now
   // belongs to the previously presented address.
   assign restore_we   = ((r_state == LOAD) && (r_cnt != '0)) || (r_state == LAST);
   assign restore_addr = r_cnt[AW-1:0] - c_addr_one;
   assign restore_data = ctx_mem_rdata;

endmodule

`default_nettype wire

// File: rtl/regfile_mpmw_ctx.sv
// ============================================================================
// Module      : regfile_mpmw_ctx
// Description : Multi-read / multi-write register file with DM lane write,
//               DM lane read and a context save/restore engine.
// Ports       : clk, rst_n                 clock, synchronous active-low reset
//               rd_addr/rd_data            NR combinational read ports
//               wr_en/wr_addr/wr_data      NW datapath write ports
//               dm_wen/dm_addr_w/dm_data_w LANES-wide DM write (lane 0 MSBs)
//               dm_addr_r/dm_data_r        DM read port
//               ctx_req/ctx_dir            context transfer request
//               ctx_busy/ctx_done          context engine status
//               ctx_mem_*                  context memory interface
// Config      : RF_BYPASS_EN - reads return the data being written this cycle
//               (same priority as the write) instead of the stored value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mpmw_ctx
   import rf_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int NR    = 5,
   parameter int NW    = 3,
   parameter int LANES = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NR*AW-1:0]    rd_addr,
   output logic [NR*W-1:0]     rd_data,
   input  logic [NW-1:0]       wr_en,
   input  logic [NW*AW-1:0]    wr_addr,
   input  logic [NW*W-1:0]     wr_data,
   input  logic                dm_wen,
   input  logic [LANES*AW-1:0] dm_addr_w,
   input  logic [LANES*W-1:0]  dm_data_w,
   input  logic [AW-1:0]       dm_addr_r,
   output logic [W-1:0]        dm_data_r,
   input  logic                ctx_req,
   input  logic                ctx_dir,
   output logic                ctx_busy,
   output logic                ctx_done,
   output logic [AW-1:0]       ctx_mem_addr,
   output logic                ctx_mem_we,
   output logic [W-1:0]        ctx_mem_wdata,
   input  logic [W-1:0]        ctx_mem_rdata
);

   logic [W-1:0]  r_file [DEPTH];
   logic [W-1:0]  w_next [DEPTH];

   logic          w_restore_we;
   logic [AW-1:0] w_restore_addr;
   logic [W-1:0]  w_restore_data;
   logic [W-1:0]  w_save_data;

   assign w_save_data = r_file[ctx_mem_addr];

   rf_ctx_seq #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ctx_seq (
      .clk           (clk),
      .rst_n         (rst_n),
      .ctx_req       (ctx_req),
      .ctx_dir       (ctx_dir),
      .save_data     (w_save_data),
      .ctx_mem_rdata (ctx_mem_rdata),
      .ctx_busy      (ctx_busy),
      .ctx_done      (ctx_done),
      .ctx_mem_addr  (ctx_mem_addr),
      .ctx_mem_we    (ctx_mem_we),
      .ctx_mem_wdata (ctx_mem_wdata),
      .restore_we    (w_restore_we),
      .restore_addr  (w_restore_addr),
      .restore_data  (w_restore_data)
   );

   // Next-state view of the whole file. Sources are applied in ascending
   // priority order so the last matching assignment wins outright.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_next[i] = r_file[i];
      end
      if (!ctx_busy) begin
         for (int p = 0; p < NW; p++) begin
            if (wr_en[p]) begin
               w_next[wr_addr[p*AW +: AW]] = wr_data[p*W +: W];
            end
         end
         if (dm_wen) begin
            for (int l = 0; l < LANES; l++) begin
               w_next[dm_addr_w[(LANES-1-l)*AW +: AW]] = dm_data_w[(LANES-1-l)*W +: W];
            end
         end
      end
      if (w_restore_we) begin
         w_next[w_restore_addr] = w_restore_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_file[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            r_file[i] <= w_next[i];
         end
      end
   end

   generate
      for (genvar g = 0; g < NR; g++) begin : g_rd
`ifdef RF_BYPASS_EN
         assign rd_data[g*W +: W] = w_next[rd_addr[g*AW +: AW]];
`else
         assign rd_data[g*W +: W] = r_file[rd_addr[g*AW +: AW]];
`endif
      end
   endgenerate

`ifdef RF_BYPASS_EN
   assign dm_data_r = w_next[dm_addr_r];
`else
   assign dm_data_r = r_file[dm_addr_r];
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_mpmw_ctx.sv
`default_nettype none

module tb_regfile_mpmw_ctx;

   localparam int W     = 16;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int NR    = 5;
   localparam int NW    = 3;
   localparam int LANES = 5;

   localparam int S_BUSY = 6;
   localparam int S_DONE = 7;
   localparam int S_WE   = 8;
   localparam int S_ADDR = 9;
   localparam int S_DMR  = 5;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NR*AW-1:0]    rd_addr;
   logic [NR*W-1:0]     rd_data;
   logic [NW-1:0]       wr_en;
   logic [NW*AW-1:0]    wr_addr;
   logic [NW*W-1:0]     wr_data;
   logic                dm_wen;
   logic [LANES*AW-1:0] dm_addr_w;
   logic [LANES*W-1:0]  dm_data_w;
   logic [AW-1:0]       dm_addr_r;
   logic [W-1:0]        dm_data_r;
   logic                ctx_req;
   logic                ctx_dir;
   logic                ctx_busy;
   logic                ctx_done;
   logic [AW-1:0]       ctx_mem_addr;
   logic                ctx_mem_we;
   logic [W-1:0]        ctx_mem_wdata;
   logic [W-1:0]        ctx_mem_rdata = '0;

   regfile_mpmw_ctx #(
      .W(W), .DEPTH(DEPTH), .AW(AW), .NR(NR), .NW(NW), .LANES(LANES)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .dm_wen        (dm_wen),
      .dm_addr_w     (dm_addr_w),
      .dm_data_w     (dm_data_w),
      .dm_addr_r     (dm_addr_r),
      .dm_data_r     (dm_data_r),
      .ctx_req       (ctx_req),
      .ctx_dir       (ctx_dir),
      .ctx_busy      (ctx_busy),
      .ctx_done      (ctx_done),
      .ctx_mem_addr  (ctx_mem_addr),
      .ctx_mem_we    (ctx_mem_we),
      .ctx_mem_wdata (ctx_mem_wdata),
      .ctx_mem_rdata (ctx_mem_rdata)
   );

   always #5 clk = ~clk;

   // Context memory: returns 0xA000 | addr one cycle after the address.
   always @(posedge clk) ctx_mem_rdata <= 16'hA000 | {12'h000, ctx_mem_addr};

   typedef struct {
      int          sel;
      logic [15:0] exp;
      string       name;
   } chk_t;

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] data;
   } save_t;

   chk_t  chk_q[$];
   save_t save_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   logic  final_chk = 1'b0;
   chk_t  m_c;
   save_t m_s;
   logic [15:0] m_act;

   function automatic logic [15:0] act_of(input int sel);
      case (sel)
         0, 1, 2, 3, 4: act_of = rd_data[sel*W +: W];
         S_DMR:         act_of = dm_data_r;
         S_BUSY:        act_of = {15'h0, ctx_busy};
         S_DONE:        act_of = {15'h0, ctx_done};
         S_WE:          act_of = {15'h0, ctx_mem_we};
         S_ADDR:        act_of = {12'h0, ctx_mem_addr};
         default:       act_of = 16'hxxxx;
      endcase
   endfunction

   // Monitor: drains expectations pushed for this cycle and checks every
   // memory write strobe against the save scoreboard.
   always @(negedge clk) begin
      while (chk_q.size() > 0) begin
         m_c   = chk_q.pop_front();
         m_act = act_of(m_c.sel);
         n_vec++;
         if (m_act !== m_c.exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", m_c.name, m_act, m_c.exp);
         end
      end
      if (ctx_mem_we !== 1'b0) begin
         n_vec++;
         if (save_q.size() == 0) begin
            n_err++;
            $display("FAIL save_unexpected: got we=%b addr %h, expected no write", ctx_mem_we, ctx_mem_addr);
         end else begin
            m_s = save_q.pop_front();
            if (ctx_mem_addr !== m_s.addr || ctx_mem_wdata !== m_s.data) begin
               n_err++;
               $display("FAIL save_word: got addr %h data %h, expected addr %h data %h",
                        ctx_mem_addr, ctx_mem_wdata, m_s.addr, m_s.data);
            end
         end
      end
      if (final_chk) begin
         n_vec++;
         if (save_q.size() != 0) begin
            n_err++;
            $display("FAIL save_missing: got %0d words outstanding, expected 0", save_q.size());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_chk(input int sel, input logic [15:0] exp, input string name);
      chk_t c;
      c.sel  = sel;
      c.exp  = exp;
      c.name = name;
      chk_q.push_back(c);
   endtask

   task automatic expect_save(input logic [3:0] a, input logic [15:0] d);
      save_t s;
      s.addr = a;
      s.data = d;
      save_q.push_back(s);
   endtask

   task automatic rd_chk(input int p, input logic [3:0] a, input logic [15:0] exp, input string name);
      rd_addr[p*AW +: AW] = a;
      expect_chk(p, exp, name);
   endtask

   task automatic set_wr(input int p, input logic [3:0] a, input logic [15:0] d);
      wr_en[p]            = 1'b1;
      wr_addr[p*AW +: AW] = a;
      wr_data[p*W +: W]   = d;
   endtask

   task automatic set_lane(input int l, input logic [3:0] a, input logic [15:0] d);
      dm_addr_w[(LANES-1-l)*AW +: AW] = a;
      dm_data_w[(LANES-1-l)*W +: W]   = d;
   endtask

   task automatic quiet();
      wr_en   = '0;
      dm_wen  = 1'b0;
      ctx_req = 1'b0;
   endtask

   task automatic status(input logic busy, input logic done, input string name);
      expect_chk(S_BUSY, {15'h0, busy}, {name, "_busy"});
      expect_chk(S_DONE, {15'h0, done}, {name, "_done"});
   endtask

   initial begin
      quiet();
      rst_n     = 1'b0;
      ctx_dir   = 1'b0;
      rd_addr   = '0;
      wr_addr   = '0;
      wr_data   = '0;
      dm_addr_w = '0;
      dm_data_w = '0;
      dm_addr_r = '0;
      tick();
      tick();
      rst_n = 1'b1;

      // Reset state
      rd_chk(0, 4'd0, 16'h0000, "rst_r0");
      rd_chk(1, 4'd15, 16'h0000, "rst_r15");
      status(1'b0, 1'b0, "rst");
      expect_chk(S_WE, 16'h0, "rst_we");
      expect_chk(S_ADDR, 16'h0, "rst_addr");
      tick();

      // 1: reset clears the file
      set_wr(0, 4'd3, 16'hBEEF);
      tick();
      quiet();
      rd_chk(0, 4'd3, 16'hBEEF, "t1_write_r3");
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      rd_chk(0, 4'd3, 16'h0000, "t1_reset_r3");
      expect_chk(S_BUSY, 16'h0, "t1_busy");
      tick();

      // 2: write priority
      set_wr(0, 4'd5, 16'h1111);
      set_wr(2, 4'd5, 16'h2222);
      for (int l = 0; l < 4; l++) set_lane(l, 4'(l), 16'hD000 + 16'(l));
      set_lane(4, 4'd5, 16'h3333);
      dm_wen = 1'b1;
      tick();
      quiet();
      rd_chk(0, 4'd5, 16'h3333, "t2_dm_over_ports");
      rd_chk(1, 4'd0, 16'hD000, "t2_lane0");
      rd_chk(4, 4'd3, 16'hD003, "t2_lane3");
      dm_addr_r = 4'd2;
      expect_chk(S_DMR, 16'hD002, "t2_dm_read");
      tick();
      set_wr(0, 4'd5, 16'h1111);
      set_wr(2, 4'd5, 16'h2222);
      tick();
      quiet();
      rd_chk(0, 4'd5, 16'h2222, "t2_port2_over_port0");
      tick();
      set_wr(2, 4'd6, 16'h2222);
      set_lane(0, 4'd6, 16'hAAAA);
      set_lane(1, 4'd7, 16'h7777);
      set_lane(2, 4'd8, 16'h8888);
      set_lane(3, 4'd10, 16'hA0A0);
      set_lane(4, 4'd6, 16'hBBBB);
      dm_wen = 1'b1;
      tick();
      quiet();
      rd_chk(0, 4'd6, 16'hBBBB, "t2_lane4_over_lane0");
      rd_chk(1, 4'd7, 16'h7777, "t2_lane1");
      dm_addr_r = 4'd10;
      expect_chk(S_DMR, 16'hA0A0, "t2_lane3_dm_read");
      tick();

      // 3: save
      for (int k = 0; k < DEPTH; k += 3) begin
         for (int p = 0; p < NW; p++) begin
            if (k + p < DEPTH) set_wr(p, 4'(k + p), 16'h0100 + 16'(k + p));
         end
         tick();
         quiet();
      end
      ctx_dir = 1'b0;
      ctx_req = 1'b1;
      expect_chk(S_BUSY, 16'h0, "t3_idle_busy");
      tick();
      ctx_req = 1'b0;
      for (int k = 0; k < DEPTH; k++) expect_save(4'(k), 16'h0100 + 16'(k));
      for (int k = 0; k < DEPTH; k++) begin
         status(1'b1, 1'b0, "t3_save");
         tick();
      end
      status(1'b1, 1'b1, "t3_done");
      expect_chk(S_WE, 16'h0, "t3_done_we");
      ctx_req = 1'b1;
      tick();
      ctx_req = 1'b0;
      status(1'b0, 1'b0, "t3_idle");
      tick();
      status(1'b0, 1'b0, "t3_req_in_done_ignored");
      tick();

      // 4: restore, with dropped external writes
      ctx_dir = 1'b1;
      ctx_req = 1'b1;
      tick();
      ctx_req = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         status(1'b1, 1'b0, "t4_load");
         expect_chk(S_ADDR, 16'(k), "t4_load_addr");
         if (k == 5) set_wr(0, 4'd2, 16'hDEAD);
         if (k == 6) begin
            for (int l = 0; l < LANES; l++) set_lane(l, 4'd4, 16'hBAD0 + 16'(l));
            dm_wen = 1'b1;
         end
         tick();
         quiet();
      end
      status(1'b1, 1'b0, "t4_last");
      tick();
      status(1'b1, 1'b1, "t4_done");
      for (int l = 0; l < LANES; l++) set_lane(l, 4'd15, 16'hFFFF);
      dm_wen = 1'b1;
      tick();
      quiet();
      status(1'b0, 1'b0, "t4_idle");
      for (int k = 0; k < DEPTH; k++) begin
         rd_chk(k % NR, 4'(k), 16'hA000 + 16'(k), "t4_restored");
         if ((k % NR) == NR - 1 || k == DEPTH - 1) tick();
      end

      // 5: reset aborts a restore
      ctx_dir = 1'b1;
      ctx_req = 1'b1;
      tick();
      ctx_req = 1'b0;
      for (int k = 0; k < 7; k++) begin
         expect_chk(S_ADDR, 16'(k), "t5_load_addr");
         tick();
      end
      status(1'b1, 1'b0, "t5_k7");
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      status(1'b0, 1'b0, "t5_abort");
      expect_chk(S_ADDR, 16'h0, "t5_abort_addr");
      for (int k = 0; k < DEPTH; k++) begin
         rd_chk(k % NR, 4'(k), 16'h0000, "t5_cleared");
         if ((k % NR) == NR - 1 || k == DEPTH - 1) begin
            expect_chk(S_DONE, 16'h0, "t5_no_done");
            tick();
         end
      end
      ctx_dir = 1'b0;
      ctx_req = 1'b1;
      tick();
      ctx_req = 1'b0;
      for (int k = 0; k < DEPTH; k++) expect_save(4'(k), 16'h0000);
      for (int k = 0; k < DEPTH; k++) begin
         status(1'b1, 1'b0, "t5_save");
         tick();
      end
      status(1'b1, 1'b1, "t5_done");
      tick();
      status(1'b0, 1'b0, "t5_idle");
      tick();

      // 6: same-cycle read of a committing write
      set_wr(0, 4'd9, 16'h1234);
      tick();
      quiet();
      set_wr(1, 4'd9, 16'h5A5A);
      dm_addr_r = 4'd9;
`ifdef RF_BYPASS_EN
      rd_chk(0, 4'd9, 16'h5A5A, "t6_same_cycle_rd");
      expect_chk(S_DMR, 16'h5A5A, "t6_same_cycle_dm");
`else
      rd_chk(0, 4'd9, 16'h1234, "t6_same_cycle_rd");
      expect_chk(S_DMR, 16'h1234, "t6_same_cycle_dm");
`endif
      tick();
      quiet();
      rd_chk(0, 4'd9, 16'h5A5A, "t6_after_edge");
      tick();

      final_chk = 1'b1;
      @(negedge clk);
      #1;
      final_chk = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
